musb_timer: RTL
===============

# musb_timer

Memory-mapped 32-bit timer/compare peripheral for the MUSB SoC. It is a bus slave: it answers the single-master slave-side handshake of the crossbar `mux_switch` (address, data, byte-write, enable in; data, ready out). It sits beside GPIO and UART as a new slave port and drives one level interrupt into the core's `interrupts` vector.

## Interface
- `RESET_COMPARE`, default 32'hFFFF_FFFF: reset value of the COMPARE register.
- `clk`  in  1: bus clock (`clk_bus`).
- `rst`  in  1: asynchronous, active-low reset.
- `timer_address`  in  5: byte address `slave_address[4:0]`; register select is `[4:2]`.
- `timer_data_i`  in  32: write data.
- `timer_wr`  in  4: byte write enables; any bit set makes a write, 0 makes a read.
- `timer_enable`  in  1: access request, held by the master until `timer_ready`.
- `timer_data_o`  out  32: read data, valid only while `timer_ready`=1.
- `timer_ready`  out  1: one-cycle completion pulse.
- `timer_interrupt`  out  1: level interrupt, `STATUS.match & CTRL.ie`.
- `capture_i`  in  1: asynchronous capture strobe. Used only with `TIMER_CAPTURE_EN`, otherwise ignored.

## Operation
- Register map, word offsets:
  - 0x00 CTRL: [0] `en`, [1] `autoreload`, [2] `ie`.
  - 0x04 STATUS: [0] `match`, write-1-to-clear.
  - 0x08 COUNT: 32 bits.
  - 0x0C COMPARE: 32 bits.
  - 0x10 PRESCALE: [15:0].
  - 0x14 CAPTURE: read-only.
  - 0x18 and 0x1C: unmapped.
- Byte writes: `timer_wr[i]` updates byte i only. Unused bits read 0.
- Unmapped offsets read 32'h0 and ignore writes, but `timer_ready` is still returned. The slave never hangs the bus.
- Prescaler: a 16-bit counter runs while `en`=1. It produces `tick` every PRESCALE+1 clocks, so PRESCALE=0 ticks every cycle. The prescaler counter is held at 0 while `en`=0.
- On each `tick`:
  - COUNT ≠ COMPARE: COUNT increments modulo 2^32. Wrap from FFFF_FFFF to 0 is silent.
  - COUNT = COMPARE: `match` is set.
    - `autoreload`=1: COUNT goes to 0 and the timer keeps running.
    - `autoreload`=0: COUNT holds and `en` clears to 0 (one-shot).
- Precedence within one cycle:
  - A bus write to COUNT or CTRL beats a tick update.
  - A hardware `match` set beats a software clear of STATUS.
- Access FSM states:
  - IDLE: on `timer_enable`=1, the write is performed or the read data is registered. Go to RESP.
  - RESP: `timer_ready`=1 for one cycle. Go to WAIT.
  - WAIT: return to IDLE once `timer_enable`=0, or immediately if the master already dropped it.
  - Effect: one held enable yields exactly one access. Back-to-back accesses need enable low for at least one cycle.

## Timing
- Reset values while `rst`=0:
  - CTRL=0, STATUS=0, COUNT=0, COMPARE=`RESET_COMPARE`, PRESCALE=0, CAPTURE=0.
  - FSM in IDLE.
  - `timer_ready`=0, `timer_data_o`=0, `timer_interrupt`=0.
- Access latency: enable sampled at edge N, `timer_ready` high during cycle N+1, low at N+2.
- Write effects are visible to a read issued after the ready cycle.
- Read of COUNT returns its value at the IDLE sampling edge.
- `match` and the interrupt rise on the edge after the matching tick.
- Reset asserted mid-access: the access is aborted, no ready is given, and all state returns to reset values.

## Configuration
- `TIMER_CAPTURE_EN` defined:
  - `capture_i` passes through a 2-flop synchronizer with rising-edge detect.
  - On each detected edge, CAPTURE latches COUNT. This happens even when `en`=0.
  - Latency from the `capture_i` rise to the CAPTURE update is 3 clocks.
- Not defined:
  - CAPTURE reads 0 and `capture_i` is unused.
  - No synchronizer flops are built.

## Structure
- Shared package/header `musb_timer_pkg`:
  - register offsets;
  - CTRL/STATUS bit indices;
  - FSM state encodings (IDLE, RESP, WAIT).
- One sub-module, `timer_prescaler`: 16-bit divider with `en` and `div` inputs and a `tick` output.
- Register file, compare logic and bus FSM live in `musb_timer`.

## Test plan
- Reset and read-back:
  - Stimulus: hold `rst`=0 for 4 cycles, release, read every offset.
  - Required: CTRL/COUNT/STATUS read 0, COMPARE reads FFFF_FFFF, 0x18 reads 0, and one ready per access.
- Auto-reload periodic run:
  - Stimulus: PRESCALE=3, COMPARE=9, CTRL=0x7.
  - Required: `timer_interrupt` rises every 40 clocks. Clear STATUS, and the interrupt drops the next cycle.
- One-shot:
  - Stimulus: COMPARE=5, PRESCALE=0, CTRL=0x1.
  - Required: COUNT stops at 5, CTRL.en reads 0, STATUS=1.
- Byte write and wrap:
  - Stimulus: write COUNT=FFFF_FFFE, then `timer_wr`=4'b0010 with data 0000_AB00 while disabled.
  - Required: COUNT=FFFF_ABFE. Then enable with COMPARE=3, and COUNT wraps FFFF_FFFF→0 without setting `match`.
- Collisions:
  - Stimulus: write STATUS=1 in the same cycle as a hardware match.
  - Required: `match` stays 1.
  - Stimulus: write COUNT=0x100 on a tick cycle.
  - Required: COUNT reads 0x100.
- Handshake and capture:
  - Stimulus: hold `timer_enable` high for 6 cycles.
  - Required: exactly one ready pulse.
  - Stimulus (`TIMER_CAPTURE_EN` defined): pulse `capture_i` with COUNT=0x20 counting each cycle.
  - Required: CAPTURE=0x22.

Source files
------------

// File: rtl/musb_timer_pkg.sv
// Shared constants for the MUSB timer/compare peripheral: register offsets,
// CTRL/STATUS bit positions, bus FSM encodings and a byte-merge helper.
package musb_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_CAPTURE  = 3'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AR      = 1;
    localparam int CTRL_IE      = 2;
    localparam int STATUS_MATCH = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/musb_timer_prescaler.sv
// 16-bit clock divider: tick every div+1 enabled clocks, counter parked at 0 while disabled.
module timer_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_q, cnt_d;

    // >= rather than == so a shrinking div mid-run cannot strand the counter above it
    assign tick = en && (cnt_q >= div);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) cnt_d = '0;
        else             cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/musb_timer.sv
// MUSB timer/compare bus slave: register file, compare logic and access FSM.
// Optional capture input is built only when TIMER_CAPTURE_EN is defined.
//
// state | meaning
// IDLE  | waiting for timer_enable; performs the write or registers read data
// RESP  | timer_ready high for exactly one cycle
// WAIT  | holds off until the master drops timer_enable
module musb_timer
    import musb_timer_pkg::*;
#(
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  timer_address,
    input  logic [31:0] timer_data_i,
    input  logic [3:0]  timer_wr,
    input  logic        timer_enable,
    output logic [31:0] timer_data_o,
    output logic        timer_ready,
    output logic        timer_interrupt,
    input  logic        capture_i
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        match_q, match_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;
    logic [31:0] capture_val;
    logic [2:0]  reg_sel;
    logic        accept, wr_en, tick, count_hit;

    assign reg_sel   = timer_address[4:2];
    assign accept    = (state_q == ST_IDLE) && timer_enable;
    assign wr_en     = accept && (|timer_wr);
    assign count_hit = (count_q == compare_q);

    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst),
        .en    (ctrl_q[CTRL_EN]),
        .div   (prescale_q),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (timer_enable)  state_d = ST_RESP;
            ST_RESP:                    state_d = ST_WAIT;
            ST_WAIT: if (!timer_enable) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_CTRL:     rd_mux = {29'd0, ctrl_q};
            REG_STATUS:   rd_mux = {31'd0, match_q};
            REG_COUNT:    rd_mux = count_q;
            REG_COMPARE:  rd_mux = compare_q;
            REG_PRESCALE: rd_mux = {16'd0, prescale_q};
            REG_CAPTURE:  rd_mux = capture_val;
            default:      rd_mux = '0;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (accept) rdata_d = wr_en ? 32'd0 : rd_mux;
    end

    // Ordering below encodes priority: tick update, then bus write, then hardware match set
    always_comb begin
        ctrl_d     = ctrl_q;
        match_d    = match_q;
        count_d    = count_q;
        compare_d  = compare_q;
        prescale_d = prescale_q;

        if (tick) begin
            if (count_hit) begin
                if (ctrl_q[CTRL_AR]) count_d = '0;
                else                 ctrl_d[CTRL_EN] = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_en) begin
            case (reg_sel)
                REG_CTRL:     if (timer_wr[0]) ctrl_d = timer_data_i[2:0];
                REG_STATUS:   if (timer_wr[0] && timer_data_i[STATUS_MATCH]) match_d = 1'b0;
                REG_COUNT:    count_d   = byte_merge(count_q, timer_data_i, timer_wr);
                REG_COMPARE:  compare_d = byte_merge(compare_q, timer_data_i, timer_wr);
                REG_PRESCALE: begin
                    if (timer_wr[0]) prescale_d[7:0]  = timer_data_i[7:0];
                    if (timer_wr[1]) prescale_d[15:8] = timer_data_i[15:8];
                end
                default: ;
            endcase
        end

        if (tick && count_hit) match_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            match_q    <= 1'b0;
            count_q    <= '0;
            compare_q  <= RESET_COMPARE;
            prescale_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            match_q    <= match_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [2:0]  cap_sync_q, cap_sync_d;
    logic [31:0] capture_q, capture_d;
    logic        cap_edge;
    logic [1:0]  unused_sig;

    assign unused_sig = timer_address[1:0];
    // [1:0] synchronize, [2] is the previous synchronized level for edge detect
    assign cap_edge   = cap_sync_q[1] & ~cap_sync_q[2];

    always_comb begin
        cap_sync_d = {cap_sync_q[1:0], capture_i};
        capture_d  = cap_edge ? count_q : capture_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_sync_q <= '0;
            capture_q  <= '0;
        end else begin
            cap_sync_q <= cap_sync_d;
            capture_q  <= capture_d;
        end
    end

    assign capture_val = capture_q;
`else
    logic [2:0] unused_sig;

    assign unused_sig  = {capture_i, timer_address[1:0]};
    assign capture_val = '0;
`endif

    assign timer_ready     = (state_q == ST_RESP);
    assign timer_data_o    = timer_ready ? rdata_q : 32'd0;
    assign timer_interrupt = match_q & ctrl_q[CTRL_IE];

endmodule
